// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the UART receive controller.
// Config word layout, FIFO status word layout and FSM encoding.
package uart_pkg;

  localparam int CFG_D_POS   = 3;
  localparam int CFG_S_POS   = 2;
  localparam int CFG_PAR_LSB = 0;

  typedef struct packed {
    logic       d_num;
    logic       s_num;
    logic [1:0] par;
  } cfg_t;

  localparam cfg_t CFG_8N1 = '{d_num: 1'b1, s_num: 1'b0, par: 2'b00};

  localparam int RD_W = 10;

  typedef struct packed {
    logic       frm;
    logic       par;
    logic [7:0] data;
  } rd_word_t;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_APPLY    = 2'd3
  } state_t;

  function automatic cfg_t cfg_unpack(input logic [3:0] v);
    cfg_t c;
    c.d_num = v[CFG_D_POS];
    c.s_num = v[CFG_S_POS];
    c.par   = v[CFG_PAR_LSB+:2];
    return c;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through frame FIFO.
// Power-of-two depth; pointers wrap naturally.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  count
);

  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          wr;
  logic          rd;

  assign empty   = (count == '0);
  assign full    = (count == FULL_N);
  assign rd      = pop & ~empty;
  // A pop frees the slot, so a push into a full FIFO is fine then
  assign wr      = push & (~full | rd);
  assign rd_data = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive control, config shadowing, frame FIFO.
// Define UART_RX_CTRL_ERRCNT_EN to build the errored-frame counter.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_en,
  input  logic             cfg_wr,
  input  logic [3:0]       cfg_din,
  output logic             cfg_busy,
  output logic             D_num,
  output logic             S_num,
  output logic [1:0]       Par,
  output logic             rx_enable,
  input  logic             is_active,
  input  logic             rx_done,
  input  logic             par_flag,
  input  logic             framing_flag,
  input  logic [7:0]       d_in,
  input  logic             rd_en,
  output logic [RD_W-1:0]  rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [ERR_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam int AW = $clog2(DEPTH);

  state_t   state;
  cfg_t     cfg_q;
  cfg_t     cfg_pend;
  rd_word_t wr_word;
  logic     pend;
  logic     rx_done_d;
  logic     armed;
  logic     push;
  logic     pop;
  logic     fall;
  logic     go_dis;
  logic     empty;
  logic [AW:0] occ_unused;

  // armed blocks a push from an rx_done already high at reset release
  assign push     = rx_done & ~rx_done_d & armed;
  assign fall     = ~rx_done & rx_done_d;
  assign pop      = rd_en & rd_valid;
  assign go_dis   = ~ctrl_en & ~is_active;
  assign rd_valid = ~empty;
  assign cfg_busy = pend;
  assign {D_num, S_num, Par} = cfg_q;
  assign wr_word  = '{frm: framing_flag, par: par_flag, data: d_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_DISABLED;
      cfg_q    <= CFG_8N1;
      cfg_pend <= CFG_8N1;
      pend     <= 1'b0;
    end else begin
      if (go_dis) begin
        state <= ST_DISABLED;
      end else begin
        unique case (state)
          ST_DISABLED: if (ctrl_en) state <= ST_IDLE;
          ST_IDLE:     if (is_active) state <= ST_ACTIVE;
          ST_ACTIVE:   if (fall)
                         state <= (pend || cfg_wr) ? ST_APPLY : ST_IDLE;
          ST_APPLY:    state <= ST_IDLE;
          default:     state <= ST_DISABLED;
        endcase
      end
      // Never change the receiver's framing mid-frame
      if (cfg_wr && state == ST_ACTIVE && !go_dis) begin
        cfg_pend <= cfg_unpack(cfg_din);
        pend     <= 1'b1;
      end else if (cfg_wr) begin
        cfg_q <= cfg_unpack(cfg_din);
        pend  <= 1'b0;
      end else if (pend && (state == ST_APPLY || go_dis)) begin
        cfg_q <= cfg_pend;
        pend  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_done_d <= 1'b0;
      armed     <= 1'b0;
      rx_enable <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rx_done_d <= rx_done;
      armed     <= 1'b1;
      rx_enable <= ctrl_en & ~full & ~pend;
      if (push && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
    end
  end

`ifdef UART_RX_CTRL_ERRCNT_EN
  logic [ERR_W-1:0] err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= '0;
    end else if (err_clr) begin
      err_q <= '0;
    end else if (push && (par_flag || framing_flag) && err_q != '1) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_cnt = err_q;
`else
  logic err_clr_unused;

  assign err_clr_unused = err_clr;
  assign err_cnt        = '0;
`endif

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .W     (RD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_word),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (occ_unused)
  );

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DEPTH, 4, frame FIFO depth (power of 2, 2..16).
REQ-002 Parameter ERR_W, 8, error counter width.
REQ-003 clk  in  1  system clock; all state on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 ctrl_en  in  1  software enable for reception.
REQ-006 cfg_wr  in  1  one-cycle config write strobe.
REQ-007 cfg_din  in  4  {D_num, S_num, Par[1:0]} config value.
REQ-008 cfg_busy  out  1  config write pending (not yet applied).
REQ-009 D_num, S_num, Par  out  1,1,2  applied config to receiver.
REQ-010 rx_enable  out  1  receiver enable.
REQ-011 is_active  in  1  receiver mid-frame indication.
REQ-012 rx_done, par_flag, framing_flag  in  1,1,1  receiver frame-complete level and error flags.
REQ-013 d_in  in  8  receiver data, valid while rx_done high.
REQ-014 rd_en  in  1  consumer pop strobe.
REQ-015 rd_data  out  10  {framing_flag, par_flag, data[7:0]} at FIFO head.
REQ-016 rd_valid, full  out  1,1  FIFO non-empty and FIFO full.
REQ-017 overflow  out  1  sticky frame-dropped flag; ovf_clr in 1 clears it.
REQ-018 err_cnt  out  ERR_W  errored-frame count; err_clr in 1 clears it.

Function
REQ-019 FSM states: DISABLED (ctrl_en=0), IDLE (enabled, receiver idle), ACTIVE (is_active=1), APPLY (one cycle, pending config copied to outputs).
REQ-020 Transitions: DISABLED->IDLE when ctrl_en=1; IDLE->ACTIVE when is_active=1; ACTIVE->APPLY on rx_done falling edge if pending, else ->IDLE; APPLY->IDLE; any state->DISABLED when ctrl_en=0 and is_active=0.
REQ-021 cfg_wr in DISABLED or IDLE: config outputs update on the next clock edge; cfg_busy stays 0.
REQ-022 cfg_wr in ACTIVE: value held pending, cfg_busy=1 until APPLY completes; a second cfg_wr while pending overwrites the pending value.
REQ-023 rx_enable = ctrl_en AND NOT full AND NOT cfg_busy, registered (one-cycle latency).
REQ-024 Push occurs on rising edge of rx_done only (rx_done registered, push = rx_done AND NOT rx_done_d); a held rx_done produces exactly one push.
REQ-025 Pushed entry = {framing_flag, par_flag, d_in} sampled in the push cycle; rd_data/rd_valid reflect it one clock later (first-word fall-through).
REQ-026 rd_en with rd_valid=1 pops the head; rd_en with rd_valid=0 is ignored.
REQ-027 Simultaneous push and pop when full: both occur, occupancy unchanged, overflow not set.
REQ-028 Push when full without pop: frame dropped, FIFO unchanged, overflow set next cycle.
REQ-029 overflow clears on ovf_clr; set and clear in the same cycle: set wins.
REQ-030 err_cnt increments by 1 per push with par_flag OR framing_flag (dropped frames included); saturates at all-ones; err_clr and increment in the same cycle: clear wins.
REQ-031 Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.

Reset
REQ-032 On rst=0: state DISABLED; rx_enable=0; D_num=1, S_num=0, Par=2'b00 (8N1); cfg_busy=0; FIFO empty (rd_valid=0, full=0, rd_data=0); overflow=0; err_cnt=0; rx_done_d=0.
REQ-033 Reset mid-frame discards any pending config and all FIFO contents; no push occurs in the first cycle after reset release.

Configuration
REQ-034 Macro UART_RX_CTRL_ERRCNT_EN: defined -> err_cnt and err_clr behave per REQ-030; undefined -> no counter register, err_cnt tied to 0, err_clr ignored.

Structure
REQ-035 Shared package uart_pkg holds: config field positions in cfg_din, rd_data status-word layout, FSM state encodings, 8N1 reset config constant.
REQ-036 One sub-module uart_rx_fifo (synchronous FWFT FIFO, DEPTH x 10, full/empty/occupancy); FSM, config, edge detect and counter stay in uart_rx_ctrl.

Verification
REQ-037 Reset, ctrl_en=1, cfg_wr cfg_din=4'b1001 in IDLE -> next cycle D_num=1, S_num=0, Par=01, cfg_busy=0.
REQ-038 is_active=1, cfg_wr 4'b0110, rx_done high 20 cycles with d_in=8'hA5 -> cfg_busy=1 until APPLY, exactly one entry rd_data=10'h0A5, then D_num=0, S_num=1, Par=10.
REQ-039 Push 4 frames 8'h01..8'h04 with DEPTH=4 -> full=1, rx_enable=0; 5th push -> dropped, overflow=1; pops return 01,02,03,04 in order.
REQ-040 Full FIFO, push 8'h55 and rd_en in the same cycle -> occupancy stays 4, overflow=0, tail entry 8'h55.
REQ-041 ERR_W=2, 5 frames with par_flag=1 -> err_cnt=3 (saturated); err_clr with concurrent errored push -> err_cnt=0; macro undefined -> err_cnt=0 throughout.
REQ-042 Assert rst=0 mid-frame with 2 entries queued -> rd_valid=0, overflow=0, config 8N1 immediately.
